// File: rtl/s2mm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : s2mm_pkg
// Purpose  : Field offsets and slot helpers for packed {tlast,tuser,pixel}
//            entries. Shared by the s2mm packing FIFO and FIFO2MM stages.
// Revision : 1.0 - initial release
// ============================================================================
package s2mm_pkg;

  localparam int DEF_ENTRY_WIDTH = 10;
  localparam int PIX_LSB         = 0;
  localparam int SOF_BIT         = DEF_ENTRY_WIDTH - 2;
  localparam int EOL_BIT         = DEF_ENTRY_WIDTH - 1;

  function automatic int sof_bit(input int e);
    return e - 2;
  endfunction

  function automatic int eol_bit(input int e);
    return e - 1;
  endfunction

  // Entry j of a word is stored in slot N-1-j, so the first entry sits at the MSBs.
  function automatic int slot_index(input int n, input int j);
    return n - 1 - j;
  endfunction

  function automatic int slot_sof_bit(input int n, input int e, input int j);
    return slot_index(n, j) * e + sof_bit(e);
  endfunction

  function automatic int slot_eol_bit(input int n, input int e, input int j);
    return slot_index(n, j) * e + eol_bit(e);
  endfunction

endpackage
`default_nettype wire

// File: rtl/s2mm_word_ram.sv
`default_nettype none
// ============================================================================
// Module   : s2mm_word_ram
// Purpose  : Wide-word storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module s2mm_word_ram #(
  parameter int DEPTH_BITS = 9,
  parameter int WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/s2mm_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : s2mm_pack_fifo
// Purpose  : Packs N {tlast,tuser,pixel} entries into one wide word and
//            presents complete words first-word-fall-through.
//            Option macro: S2MM_PACK_FIFO_SOF_ALIGN_EN (forces SOF to MSB slot).
// Revision : 1.0 - initial release
// ============================================================================
module s2mm_pack_fifo
  import s2mm_pkg::*;
#(
  parameter int C_PIXEL_WIDTH      = 8,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_DEPTH_BITS       = 9,
  parameter int C_DATACOUNT_BITS   = 12
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      wr_en,
  input  logic [C_PIXEL_WIDTH+1:0]                  wr_data,
  output logic                                      full,
  input  logic                                      rd_en,
  output logic [(C_M_AXI_DATA_WIDTH/C_PIXEL_WIDTH)*(C_PIXEL_WIDTH+2)-1:0] rd_data,
  output logic                                      empty,
  output logic [C_DATACOUNT_BITS-1:0]               rd_data_count
);

  localparam int E     = C_PIXEL_WIDTH + 2;
  localparam int N     = C_M_AXI_DATA_WIDTH / C_PIXEL_WIDTH;
  localparam int W     = N * E;
  localparam int DEPTH = 2**C_DEPTH_BITS;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0]         K_LAST     = KW'(N - 1);
  localparam logic [C_DEPTH_BITS:0] COUNT_FULL = (C_DEPTH_BITS + 1)'(DEPTH);

  logic [KW-1:0]           k, k_nxt;
  logic [W-1:0]            pack, pack_nxt, merged, commit_word;
  logic [C_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [C_DEPTH_BITS:0]   count;
  logic                    accept, pop, commit;

  assign full          = (count == COUNT_FULL);
  assign empty         = (count == '0);
  assign accept        = wr_en & ~full;
  assign pop           = rd_en & ~empty;
  assign rd_data_count = C_DATACOUNT_BITS'(count);

  always_comb begin
    merged = pack;
    merged[slot_index(N, int'(k))*E +: E] = wr_data;
  end

  always_comb begin
    commit      = 1'b0;
    commit_word = merged;
    k_nxt       = k;
    pack_nxt    = pack;
    if (accept) begin
`ifdef S2MM_PACK_FIFO_SOF_ALIGN_EN
      // A mid-word SOF flushes the partial word (unfilled slots are zero in pack).
      if (wr_data[sof_bit(E)] && (k != '0)) begin
        commit      = 1'b1;
        commit_word = pack;
        pack_nxt    = '0;
        pack_nxt[slot_index(N, 0)*E +: E] = wr_data;
        k_nxt       = KW'(1);
      end else
`endif
      if (k == K_LAST) begin
        commit   = 1'b1;
        k_nxt    = '0;
        pack_nxt = '0;
      end else begin
        k_nxt    = k + 1'b1;
        pack_nxt = merged;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k      <= '0;
      pack   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      k    <= k_nxt;
      pack <= pack_nxt;
      if (commit) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({commit, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  s2mm_word_ram #(
    .DEPTH_BITS (C_DEPTH_BITS),
    .WIDTH      (W)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (wr_ptr),
    .wdata (commit_word),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_s2mm_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2mm_pack_fifo
// Purpose  : Scoreboard bench for s2mm_pack_fifo (N=4, E=10, 512 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2mm_pack_fifo;

  localparam int E     = 10;
  localparam int N     = 4;
  localparam int W     = N * E;
  localparam int DEPTH = 512;
  localparam int CB    = 12;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [E-1:0]  wr_data = '0;
  logic          full, empty;
  logic [W-1:0]  rd_data;
  logic [CB-1:0] rd_data_count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [E-1:0] m_ent[N];
  int           m_k = 0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  s2mm_pack_fifo #(
    .C_PIXEL_WIDTH      (8),
    .C_M_AXI_DATA_WIDTH (32),
    .C_DEPTH_BITS       (9),
    .C_DATACOUNT_BITS   (CB)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .rd_data_count (rd_data_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every pop the DUT will perform on the next edge must match the scoreboard head.
  always @(negedge clk) begin
    if (resetn && rd_en && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          failures++;
          $display("FAIL rd_word actual=%0h required=%0h", rd_data, mon_exp);
        end
      end
    end
  end

  task automatic m_commit();
    exp_q.push_back({m_ent[0], m_ent[1], m_ent[2], m_ent[3]});
    m_cnt++;
    m_k = 0;
    foreach (m_ent[i]) m_ent[i] = '0;
  endtask

  task automatic m_write(input logic [E-1:0] d);
`ifdef S2MM_PACK_FIFO_SOF_ALIGN_EN
    if (d[E-2] && m_k != 0) m_commit();
`endif
    m_ent[m_k] = d;
    m_k++;
    if (m_k == N) m_commit();
  endtask

  task automatic cycle(input bit we, input logic [E-1:0] d, input bit re);
    bit acc, pp;
    acc = we && (m_cnt < DEPTH);
    pp  = re && (m_cnt > 0);
    wr_en = we; wr_data = d; rd_en = re;
    @(posedge clk);
    if (acc) m_write(d);
    if (pp) m_cnt--;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] pix, input bit user, input bit last);
    cycle(1'b1, {last, user, pix}, 1'b0);
  endtask

  task automatic pop1();
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_k = 0;
    m_cnt = 0;
    foreach (m_ent[i]) m_ent[i] = '0;
  endtask

  task automatic do_reset();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(rd_data_count), 64'd0);
    model_clear();
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // 1: basic packing order
    do_reset();
    wr(8'h11, 0, 0); wr(8'h22, 0, 0); wr(8'h33, 0, 0);
    check("t1_empty_pre", 64'(empty), 64'd1);
    wr(8'h44, 0, 0);
    check("t1_empty_post", 64'(empty), 64'd0);
    check("t1_count", 64'(rd_data_count), 64'd1);
    check("t1_word", 64'(rd_data), 64'({10'h011, 10'h022, 10'h033, 10'h044}));
    pop1();
    check("t1_empty_after_pop", 64'(empty), 64'd1);

    // 2: partial word invisible
    wr(8'h5A, 0, 0); wr(8'h6B, 0, 0); wr(8'h7C, 0, 0);
    check("t2_empty_partial", 64'(empty), 64'd1);
    check("t2_count_partial", 64'(rd_data_count), 64'd0);
    wr(8'h8D, 0, 1);
    check("t2_count", 64'(rd_data_count), 64'd1);
    check("t2_word", 64'(rd_data), 64'({10'h05A, 10'h06B, 10'h07C, 10'h28D}));
    pop1();
    check("t2_empty", 64'(empty), 64'd1);
    check("t2_count_after", 64'(rd_data_count), 64'd0);

    // 3: fill, overflow drop, refill, wrap and drain
    do_reset();
    for (int i = 0; i < DEPTH * N; i++) wr(8'(i), 0, (i % 4) == 3);
    check("t3_full", 64'(full), 64'd1);
    check("t3_count_full", 64'(rd_data_count), 64'd512);
    wr(8'hEE, 1, 1);
    check("t3_count_drop", 64'(rd_data_count), 64'd512);
    pop1();
    check("t3_full_after_pop", 64'(full), 64'd0);
    check("t3_count_511", 64'(rd_data_count), 64'd511);
    for (int j = 0; j < N; j++) wr(8'(8'hC0 + j), 0, j == 3);
    check("t3_refull", 64'(full), 64'd1);
    check("t3_count_refull", 64'(rd_data_count), 64'd512);
    for (int j = 0; j < DEPTH; j++) pop1();
    check("t3_drained", 64'(empty), 64'd1);

    // 4: commit and pop in the same cycle
    do_reset();
    wr(8'h01, 0, 0); wr(8'h02, 0, 0); wr(8'h03, 0, 0); wr(8'h04, 0, 0);
    wr(8'h05, 0, 0); wr(8'h06, 0, 0); wr(8'h07, 0, 0);
    cycle(1'b1, 10'h008, 1'b1);
    check("t4_count", 64'(rd_data_count), 64'd1);
    check("t4_empty", 64'(empty), 64'd0);
    check("t4_word2", 64'(rd_data), 64'({10'h005, 10'h006, 10'h007, 10'h008}));
    pop1();
    check("t4_empty_end", 64'(empty), 64'd1);

    // 5: SOF in the middle of a word
    do_reset();
    wr(8'hA1, 0, 0); wr(8'hB2, 0, 0); wr(8'hC3, 1, 0);
`ifdef S2MM_PACK_FIFO_SOF_ALIGN_EN
    check("t5_pad_count", 64'(rd_data_count), 64'd1);
    check("t5_pad_word", 64'(rd_data), 64'({10'h0A1, 10'h0B2, 10'h000, 10'h000}));
    wr(8'hD4, 0, 0); wr(8'hE5, 0, 0); wr(8'hF6, 0, 0);
    check("t5_count2", 64'(rd_data_count), 64'd2);
    pop1();
    check("t5_sof_word", 64'(rd_data), 64'({10'h1C3, 10'h0D4, 10'h0E5, 10'h0F6}));
    pop1();
`else
    check("t5_count0", 64'(rd_data_count), 64'd0);
    wr(8'hD4, 0, 0);
    check("t5_count1", 64'(rd_data_count), 64'd1);
    check("t5_word", 64'(rd_data), 64'({10'h0A1, 10'h0B2, 10'h1C3, 10'h0D4}));
    pop1();
`endif
    check("t5_empty", 64'(empty), 64'd1);

    // 6: asynchronous reset with stored and partial words
    do_reset();
    wr(8'h21, 0, 0); wr(8'h22, 0, 0); wr(8'h23, 0, 0); wr(8'h24, 0, 0);
    wr(8'h31, 1, 0); wr(8'h32, 0, 1);
    check("t6_count_pre", 64'(rd_data_count), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_empty", 64'(empty), 64'd1);
    check("t6_async_count", 64'(rd_data_count), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    wr(8'h41, 0, 0); wr(8'h42, 0, 0); wr(8'h43, 0, 0); wr(8'h44, 0, 0);
    check("t6_count", 64'(rd_data_count), 64'd1);
    check("t6_clean_word", 64'(rd_data), 64'({10'h041, 10'h042, 10'h043, 10'h044}));
    pop1();
    check("t6_empty", 64'(empty), 64'd1);

    check("sb_final", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
